clause_sweep_ctrl: RTL

CLAUSE_SWEEP_CTRL -- requirements
Module: clause_sweep_ctrl

---
 rtl/clause_sweep_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/clause_sweep_ctrl.sv
// rtl/clause_sweep_ctrl.sv - batched clause conflict sweep over a stored assignment mask
// Optional feature: SWEEP_EARLY_ABORT_EN ends the sweep at the first conflicting batch.
module clause_sweep_ctrl #(
    parameter int NUM_CLAUSES           = 64,
    parameter int VAR_ID_BITS           = 8,
    parameter int NUM_CLAUSES_PER_CYCLE = 16,
    parameter int NUM_VARS_PER_CLAUSE   = 3,
    localparam int W  = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
    localparam int NB = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
    localparam int BB = (NB > 1) ? $clog2(NB) : 1,
    localparam int CB = $clog2(NUM_CLAUSES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    output logic          rd_req,
    output logic [BB-1:0] rd_batch,
    input  logic          rd_valid,
    output logic [W-1:0]  cur_assign,
    input  logic [W-1:0]  or_result,
    output logic          busy,
    output logic          done,
    output logic          conflict,
    output logic [CB-1:0] conflict_clause
);

    if (VAR_ID_BITS < 1 || (NUM_CLAUSES % NUM_CLAUSES_PER_CYCLE) != 0) begin : g_param_check
        $error("clause_sweep_ctrl: invalid parameter combination");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BB-1:0] batch;
    logic [W-1:0]  store [NB];
    logic          hit;
    logic [CB-1:0] hit_idx;
    logic          last_batch;
    logic          first_hit;

    assign rd_batch   = batch;
    assign cur_assign = store[batch];
    assign last_batch = (batch == BB'(NB - 1));
    assign first_hit  = hit && !conflict;

    // Scan from the top so the lowest-numbered conflicting clause wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int c = NUM_CLAUSES_PER_CYCLE - 1; c >= 0; c--) begin
            if (&or_result[c*NUM_VARS_PER_CLAUSE +: NUM_VARS_PER_CLAUSE]) begin
                hit     = 1'b1;
                hit_idx = CB'(int'(batch) * NUM_CLAUSES_PER_CYCLE + c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                rd_req    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (rd_valid) begin
`ifdef SWEEP_EARLY_ABORT_EN
                    state_nxt = (last_batch || first_hit) ? DONE : REQ;
`else
                    state_nxt = last_batch ? DONE : REQ;
`endif
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            batch           <= '0;
            conflict        <= 1'b0;
            conflict_clause <= '0;
            for (int r = 0; r < NB; r++) begin
                store[r] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        batch           <= '0;
                        conflict        <= 1'b0;
                        conflict_clause <= '0;
                    end else if (clear) begin
                        for (int r = 0; r < NB; r++) begin
                            store[r] <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (rd_valid) begin
                        store[batch] <= or_result;
                        if (first_hit) begin
                            conflict        <= 1'b1;
                            conflict_clause <= hit_idx;
                        end
                        if (state_nxt == REQ) begin
                            batch <= batch + BB'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
